// File: rtl/sfx_pkg.sv
// Shared types, sound ids, tone table and request priority for the sound-effect player.
package sfx_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, PLAY} state_t;

  localparam logic [1:0] SND_BONUS = 2'd0;
  localparam logic [1:0] SND_WIN   = 2'd1;
  localparam logic [1:0] SND_COLL  = 2'd2;
  localparam logic [1:0] SND_LOSE  = 2'd3;

  localparam int TONE_DIV_W = 16;

  // Half-periods in 50 MHz clocks: entry 1 is C5, each entry one semitone higher.
  localparam logic [TONE_DIV_W-1:0] HALF_PERIOD [16] = '{
    16'd0,     16'd47778, 16'd45096, 16'd42565,
    16'd40177, 16'd37921, 16'd35793, 16'd33784,
    16'd31888, 16'd30098, 16'd28409, 16'd26815,
    16'd25310, 16'd23889, 16'd22548, 16'd21283
  };

  function automatic logic [1:0] prio_id(input logic [3:0] req);
    if (req[3])      return SND_LOSE;
    else if (req[2]) return SND_COLL;
    else if (req[1]) return SND_WIN;
    else             return SND_BONUS;
  endfunction

endpackage

// File: rtl/sfx_rom.sv
// Note-sequence ROM: one {tone, dur} word per note, address {sound id, note index}, registered read.
module sfx_rom (
  input  logic       clk,
  input  logic [3:0] i_addr,
  output logic [7:0] o_data
);

  logic [7:0] r_data;

  // dur == 0 marks the end of a sequence shorter than four notes
  always_ff @(posedge clk) begin
    case (i_addr)
      4'h0: r_data <= 8'h93;
      4'h1: r_data <= 8'hC3;
      4'h4: r_data <= 8'h54;
      4'h5: r_data <= 8'h74;
      4'h6: r_data <= 8'h94;
      4'h7: r_data <= 8'hC8;
      4'h8: r_data <= 8'hC2;
      4'h9: r_data <= 8'h62;
      4'hC: r_data <= 8'h96;
      4'hD: r_data <= 8'h02;
      4'hE: r_data <= 8'h56;
      4'hF: r_data <= 8'h1A;
      default: r_data <= 8'h00;
    endcase
  end

  assign o_data = r_data;

endmodule

// File: rtl/sfx_player.sv
// Sound-effect player: request edge detection, priority trigger, frame-timed note
// sequencer and square-wave tone generator.
module sfx_player
  import sfx_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int NOTES = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] sound_req,
  input  logic       frame_start,
  output logic       audio_out,
  output logic       busy,
  output logic [1:0] cur_sound,
  output logic [3:0] tone
);

  localparam int IDX_W = $clog2(NOTES);

  state_t           r_state;
  logic [3:0]       r_req_d;
  logic             r_audio;
  logic             r_busy;
  logic [1:0]       r_cur_sound;
  logic [3:0]       r_tone;
  logic [3:0]       r_dur_cnt;
  logic [IDX_W-1:0] r_note_idx;
  logic [DIV_W-1:0] r_hp_cnt;

  logic [3:0]       w_new_req;
  logic [1:0]       w_cand_id;
  logic             w_trigger;
  logic [3:0]       w_rom_addr;
  logic [7:0]       w_rom_data;
  logic [3:0]       w_rom_tone;
  logic [3:0]       w_rom_dur;
  logic [DIV_W-1:0] w_hp_last;
  logic             w_note_done;
  logic             w_last_note;

  assign w_new_req   = sound_req & ~r_req_d;
  assign w_cand_id   = prio_id(w_new_req);
  // Equal id restarts the running effect; lower ids are dropped while busy
  assign w_trigger   = (w_new_req != 4'd0) && ((r_state == IDLE) || (w_cand_id >= r_cur_sound));
  assign w_rom_addr  = {r_cur_sound, 2'(r_note_idx)};
  assign w_rom_tone  = w_rom_data[7:4];
  assign w_rom_dur   = w_rom_data[3:0];
  assign w_hp_last   = DIV_W'(HALF_PERIOD[r_tone]) - DIV_W'(1);
  assign w_note_done = frame_start && (r_dur_cnt == 4'd1);
  assign w_last_note = (r_note_idx == IDX_W'(NOTES - 1));

  sfx_rom u_rom (
    .clk    (clk),
    .i_addr (w_rom_addr),
    .o_data (w_rom_data)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= IDLE;
      r_req_d     <= 4'd0;
      r_audio     <= 1'b0;
      r_busy      <= 1'b0;
      r_cur_sound <= 2'd0;
      r_tone      <= 4'd0;
      r_dur_cnt   <= 4'd0;
      r_note_idx  <= '0;
      r_hp_cnt    <= '0;
    end else begin
      r_req_d <= sound_req;
      if (w_trigger) begin
        // tone keeps its value until the new note's CHECK cycle latches it
        r_state     <= LOAD;
        r_busy      <= 1'b1;
        r_cur_sound <= w_cand_id;
        r_note_idx  <= '0;
        r_audio     <= 1'b0;
        r_hp_cnt    <= '0;
      end else begin
        case (r_state)
          LOAD: r_state <= CHECK;
          CHECK: begin
            r_audio  <= 1'b0;
            r_hp_cnt <= '0;
            if (w_rom_dur == 4'd0) begin
              r_state     <= IDLE;
              r_busy      <= 1'b0;
              r_cur_sound <= 2'd0;
              r_tone      <= 4'd0;
            end else begin
              r_state   <= PLAY;
              r_tone    <= w_rom_tone;
              r_dur_cnt <= w_rom_dur;
            end
          end
          PLAY: begin
            if (w_note_done) begin
              r_audio  <= 1'b0;
              r_hp_cnt <= '0;
              if (w_last_note) begin
                r_state     <= IDLE;
                r_busy      <= 1'b0;
                r_cur_sound <= 2'd0;
                r_tone      <= 4'd0;
              end else begin
                r_note_idx <= r_note_idx + IDX_W'(1);
                r_state    <= LOAD;
              end
            end else begin
              if (frame_start) r_dur_cnt <= r_dur_cnt - 4'd1;
              if (r_tone == 4'd0) begin
                r_audio  <= 1'b0;
                r_hp_cnt <= '0;
              end else if (r_hp_cnt == w_hp_last) begin
                r_hp_cnt <= '0;
                r_audio  <= ~r_audio;
              end else begin
                r_hp_cnt <= r_hp_cnt + DIV_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign audio_out = r_audio;
  assign busy      = r_busy;
  assign cur_sound = r_cur_sound;
  assign tone      = r_tone;

endmodule

// File: tb/tb_sfx_player.sv
// Scoreboard bench for sfx_player: expected {busy, cur_sound, tone} changes are queued
// with their cycle when stimulus is driven and checked as the outputs change.
module tb_sfx_player;

  logic       clk         = 1'b0;
  logic       resetN      = 1'b1;
  logic [3:0] sound_req   = 4'd0;
  logic       frame_start = 1'b0;
  logic       audio_out;
  logic       busy;
  logic [1:0] cur_sound;
  logic [3:0] tone;

  typedef struct {
    int         cyc;
    logic [6:0] val;
  } ev_t;

  ev_t        sb[$];
  int         cyc      = 0;
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         mon_en   = 1'b0;
  logic [6:0] mon_prev = 7'd0;
  logic [6:0] mon_now;

  sfx_player #(
    .DIV_W (16),
    .NOTES (4)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .sound_req   (sound_req),
    .frame_start (frame_start),
    .audio_out   (audio_out),
    .busy        (busy),
    .cur_sound   (cur_sound),
    .tone        (tone)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint req);
    n_checks++;
    if (obs == req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, req, req);
  endtask

  function automatic logic [6:0] pk(input logic b, input logic [1:0] s, input logic [3:0] t);
    return {b, s, t};
  endfunction

  task automatic expect_ev(input int c, input logic [6:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    sb.push_back(e);
  endtask

  // One frame pulse, optionally queuing the output change it should cause
  task automatic frame(output int fc, input bit has_ev = 1'b0, input logic [6:0] v = 7'd0,
                       input int off = 3);
    @(negedge clk);
    frame_start = 1'b1;
    fc = cyc;
    if (has_ev) expect_ev(fc + off, v);
    @(negedge clk);
    frame_start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frames(input int n);
    int f;
    repeat (n) frame(f);
  endtask

  task automatic raise(input logic [3:0] req, output int t);
    @(negedge clk);
    sound_req = req;
    t = cyc;
  endtask

  always @(negedge clk) begin
    mon_now = {busy, cur_sound, tone};
    if (mon_en && mon_now !== mon_prev) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", sb.size(), 1);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_outputs", mon_now, e.val);
      end
      $display("event cyc=%0d busy=%0b cur_sound=%0d tone=%0d", cyc, busy, cur_sound, tone);
    end
    mon_prev = mon_now;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int f;
    int e;

    #5 resetN = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cur_sound", cur_sound, 0);
    chk("rst_tone", tone, 0);
    chk("rst_audio", audio_out, 0);
    @(negedge clk);
    resetN = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single collision request from idle, level held afterwards
    raise(4'b0100, t);
    expect_ev(t + 1, pk(1'b1, 2'd2, 4'd0));
    expect_ev(t + 3, pk(1'b1, 2'd2, 4'd12));
    repeat (4) @(negedge clk);
    frame(f);
    frame(f, 1'b1, pk(1'b1, 2'd2, 4'd6));
    frame(f);
    frame(f, 1'b1, pk(1'b0, 2'd0, 4'd0));
    repeat (10) @(negedge clk);
    chk("hold_no_retrigger", busy, 0);
    raise(4'b0000, t);
    repeat (3) @(negedge clk);

    // Retrigger with a simultaneous frame pulse while the first note has one frame left
    raise(4'b0100, t);
    expect_ev(t + 1, pk(1'b1, 2'd2, 4'd0));
    expect_ev(t + 3, pk(1'b1, 2'd2, 4'd12));
    repeat (4) @(negedge clk);
    frame(f);
    raise(4'b0000, t);
    repeat (2) @(negedge clk);
    @(negedge clk);
    sound_req   = 4'b0100;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("retrig_busy", busy, 1);
    chk("retrig_tone", tone, 12);
    frame(f);
    frame(f, 1'b1, pk(1'b1, 2'd2, 4'd6));
    frame(f);
    frame(f, 1'b1, pk(1'b0, 2'd0, 4'd0));
    raise(4'b0000, t);
    repeat (3) @(negedge clk);

    // Bonus preempted by lose; a later bonus edge is dropped
    raise(4'b0001, t);
    expect_ev(t + 1, pk(1'b1, 2'd0, 4'd0));
    expect_ev(t + 3, pk(1'b1, 2'd0, 4'd9));
    repeat (4) @(negedge clk);
    frame(f);
    raise(4'b1001, t);
    expect_ev(t + 1, pk(1'b1, 2'd3, 4'd9));
    repeat (4) @(negedge clk);
    raise(4'b1000, t);
    raise(4'b1001, t);
    repeat (4) @(negedge clk);
    chk("bonus_dropped", cur_sound, 3);
    frames(5);
    frame(f, 1'b1, pk(1'b1, 2'd3, 4'd0));
    chk("rest_audio", audio_out, 0);
    frame(f);
    frame(f, 1'b1, pk(1'b1, 2'd3, 4'd5));
    frames(5);
    frame(f, 1'b1, pk(1'b1, 2'd3, 4'd1));
    e = f + 3;
    while (audio_out == 1'b0 && cyc < e + 50000) @(negedge clk);
    chk("tone1_half_period", cyc - e, 47778);
    repeat (100) @(negedge clk);
    chk("tone1_high", audio_out, 1);

    // Lower-priority edge ignored, then reset mid-note with win held high
    raise(4'b0010, t);
    repeat (3) @(negedge clk);
    chk("win_dropped", cur_sound, 3);
    @(negedge clk);
    mon_en = 1'b0;
    resetN = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_cur_sound", cur_sound, 0);
    chk("midrst_tone", tone, 0);
    chk("midrst_audio", audio_out, 0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    mon_en = 1'b1;
    t = cyc;
    expect_ev(t + 1, pk(1'b1, 2'd1, 4'd0));
    expect_ev(t + 3, pk(1'b1, 2'd1, 4'd5));
    repeat (4) @(negedge clk);
    frames(3);
    frame(f, 1'b1, pk(1'b1, 2'd1, 4'd7));
    frames(3);
    frame(f, 1'b1, pk(1'b1, 2'd1, 4'd9));
    frames(3);
    frame(f, 1'b1, pk(1'b1, 2'd1, 4'd12));
    frames(7);
    frame(f, 1'b1, pk(1'b0, 2'd0, 4'd0), 1);
    repeat (5) @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
